// File: rtl/peri_demux.sv
// Single-master to multi-slave router for the peripheral mem_if bus.
// Optional slave watchdog and response drain enabled by PERI_DEMUX_TIMEOUT_EN.
package urv_typedef;
    typedef struct packed {
        logic [31:0] req_addr;
        logic        req_write;
        logic [31:0] req_wdata;
        logic [3:0]  req_strb;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
        logic        resp_last;
    } mem_resp_t;
endpackage

module peri_demux
    import urv_typedef::*;
#(
    parameter int          SLV_NUM     = 4,
    parameter int          SEL_LSB     = 12,
    parameter int          SEL_W       = 4,
    parameter logic [31:0] PERI_BASE   = 32'h0200_0000,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               m_req_valid,
    output logic               m_req_ready,
    input  mem_req_t           m_req,
    output logic               m_resp_valid,
    input  logic               m_resp_ready,
    output mem_resp_t          m_resp,
    output logic [SLV_NUM-1:0] s_req_valid,
    input  logic [SLV_NUM-1:0] s_req_ready,
    output mem_req_t           s_req,
    input  logic [SLV_NUM-1:0] s_resp_valid,
    output logic [SLV_NUM-1:0] s_resp_ready,
    input  mem_resp_t          s_resp [SLV_NUM],
    output logic               decode_err,
    output logic               tout_err,
    output logic [31:0]        err_addr
);

    localparam int HI_LSB = SEL_LSB + SEL_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        ERR  = 3'd3,
        TOUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    mem_req_t           req_q, req_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic               decode_err_q;
    logic               tout_err_q;

    logic [SEL_W-1:0]   sel_in;
    logic               mapped;
    logic [SLV_NUM-1:0] sel_oh;
    logic               sel_req_ready;
    logic               sel_resp_valid;
    mem_resp_t          sel_resp;

    assign sel_in = m_req.req_addr[SEL_LSB +: SEL_W];
    assign mapped = (m_req.req_addr[31:HI_LSB] == PERI_BASE[31:HI_LSB])
                    && (int'(sel_in) < SLV_NUM);

    always_comb begin
        sel_oh         = '0;
        sel_req_ready  = 1'b0;
        sel_resp_valid = 1'b0;
        sel_resp       = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_oh[i]      = 1'b1;
                sel_req_ready  = s_req_ready[i];
                sel_resp_valid = s_resp_valid[i];
                sel_resp       = s_resp[i];
            end
        end
    end

`ifdef PERI_DEMUX_TIMEOUT_EN
    logic [9:0]         cnt_q, cnt_d;
    logic [SLV_NUM-1:0] drain_q, drain_d;
    logic [SLV_NUM-1:0] drain_set;
    logic               expire;
    logic               sel_drain;

    assign expire    = (cnt_q == 10'(TIMEOUT_CYC - 1));
    assign sel_drain = |(drain_q & sel_oh);
`else
    logic [9:0] unused_tout_cfg;
    assign unused_tout_cfg = 10'(TIMEOUT_CYC);
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        sel_d        = sel_q;
        err_addr_d   = err_addr_q;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp       = '0;
        s_req_valid  = '0;
        s_resp_ready = '0;
`ifdef PERI_DEMUX_TIMEOUT_EN
        cnt_d        = cnt_q;
        drain_set    = '0;
`endif
        case (state_q)
            IDLE: begin
                m_req_ready = rstn;
                if (m_req_valid) begin
                    req_d = m_req;
                    sel_d = sel_in;
                    if (mapped) begin
                        state_d = REQ;
`ifdef PERI_DEMUX_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d    = ERR;
                        err_addr_d = m_req.req_addr;
                    end
                end
            end
            REQ: begin
`ifdef PERI_DEMUX_TIMEOUT_EN
                // Hold off while a timed-out slave still owes us a response.
                if (!sel_drain) begin
                    s_req_valid = sel_oh;
                    if (sel_req_ready) begin
                        state_d = RESP;
                        cnt_d   = cnt_q + 10'd1;
                    end else if (expire) begin
                        state_d    = TOUT;
                        err_addr_d = req_q.req_addr;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
`else
                s_req_valid = sel_oh;
                if (sel_req_ready) state_d = RESP;
`endif
            end
            RESP: begin
                m_resp_valid = sel_resp_valid;
                m_resp       = sel_resp;
                s_resp_ready = sel_oh & {SLV_NUM{m_resp_ready}};
                if (sel_resp_valid && m_resp_ready) begin
                    state_d = IDLE;
`ifdef PERI_DEMUX_TIMEOUT_EN
                end else if (expire) begin
                    state_d    = TOUT;
                    err_addr_d = req_q.req_addr;
                    drain_set  = sel_oh;
                end else begin
                    cnt_d = cnt_q + 10'd1;
`endif
                end
            end
`ifdef PERI_DEMUX_TIMEOUT_EN
            ERR, TOUT: begin
`else
            ERR: begin
`endif
                m_resp_valid     = 1'b1;
                m_resp.resp_data = '0;
                m_resp.resp_last = 1'b1;
                if (m_resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef PERI_DEMUX_TIMEOUT_EN
        s_resp_ready = s_resp_ready | drain_q;
        drain_d      = (drain_q & ~s_resp_valid) | drain_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            sel_q        <= '0;
            err_addr_q   <= '0;
            decode_err_q <= 1'b0;
            tout_err_q   <= 1'b0;
`ifdef PERI_DEMUX_TIMEOUT_EN
            cnt_q        <= '0;
            drain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            sel_q        <= sel_d;
            err_addr_q   <= err_addr_d;
            decode_err_q <= (state_q == IDLE) && (state_d == ERR);
`ifdef PERI_DEMUX_TIMEOUT_EN
            tout_err_q   <= (state_q != TOUT) && (state_d == TOUT);
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
`else
            tout_err_q   <= 1'b0;
`endif
        end
    end

    assign s_req      = req_q;
    assign decode_err = decode_err_q;
    assign tout_err   = tout_err_q;
    assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_peri_demux.sv
// Directed bench for peri_demux: routing, latency, decode errors, backpressure, reset.
// Watchdog/drain steps run only when PERI_DEMUX_TIMEOUT_EN is defined.
module tb_peri_demux;
    import urv_typedef::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m_req_valid;
    logic        m_req_ready;
    mem_req_t    m_req;
    logic        m_resp_valid;
    logic        m_resp_ready;
    mem_resp_t   m_resp;
    logic [3:0]  s_req_valid;
    logic [3:0]  s_req_ready;
    mem_req_t    s_req;
    logic [3:0]  s_resp_valid;
    logic [3:0]  s_resp_ready;
    mem_resp_t   s_resp [4];
    logic        decode_err;
    logic        tout_err;
    logic [31:0] err_addr;

    logic [3:0]  slv_rdy;
    logic [3:0]  mute;
    logic [3:0]  late;
    logic [3:0]  pend;
    logic [31:0] slv_data [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    peri_demux #(.SLV_NUM(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rstn(rstn),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req(m_req),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp(m_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
        .decode_err(decode_err), .tout_err(tout_err), .err_addr(err_addr)
    );

    // Slave stand-ins: accept when ready, respond the next cycle, hold until taken.
    assign s_req_ready = slv_rdy;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rstn) pend[i] <= 1'b0;
            else if (s_req_valid[i] && s_req_ready[i] && !mute[i]) pend[i] <= 1'b1;
            else if (s_resp_valid[i] && s_resp_ready[i]) pend[i] <= 1'b0;
        end
    end
    always_comb begin
        s_resp_valid = '0;
        for (int i = 0; i < 4; i++) begin
            s_resp_valid[i]     = pend[i] | late[i];
            s_resp[i].resp_data = slv_data[i];
            s_resp[i].resp_last = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present a request for exactly one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] addr, input logic we, input logic [31:0] wd);
        m_req.req_addr  = addr;
        m_req.req_write = we;
        m_req.req_wdata = wd;
        m_req.req_strb  = 4'hF;
        m_req_valid     = 1'b1;
        cyc();
        m_req_valid     = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mreqrdy"},  m_req_ready, 1'b0);
        chk({tag, "_mrespvld"}, m_resp_valid, 1'b0);
        chk({tag, "_sreqvld"},  s_req_valid, 4'b0000);
        chk({tag, "_sresprdy"}, s_resp_ready, 4'b0000);
        chk({tag, "_decerr"},   decode_err, 1'b0);
        chk({tag, "_touterr"},  tout_err, 1'b0);
        chk({tag, "_erraddr"},  err_addr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn         = 1'b0;
        m_req_valid  = 1'b0;
        m_req        = '0;
        m_resp_ready = 1'b1;
        slv_rdy      = 4'hF;
        mute         = 4'h0;
        late         = 4'h0;
        slv_data[0]  = 32'h0000_1234;
        slv_data[1]  = 32'h1111_0001;
        slv_data[2]  = 32'h2222_0002;
        slv_data[3]  = 32'h3333_0003;
        repeat (3) cyc();
        chk_reset_outputs("rst");
        rstn = 1'b1;
        cyc();
        chk("idle_ready", m_req_ready, 1'b1);

        // clint read, zero-wait: s_req_valid in cycle 1, response in cycle 2
        send(32'h0200_0004, 1'b0, 32'h0);
        chk("rd0_sreqvld", s_req_valid, 4'b0001);
        chk("rd0_busy", m_req_ready, 1'b0);
        chk("rd0_sreqaddr", s_req.req_addr, 32'h0200_0004);
        cyc();
        chk("rd0_mrespvld", m_resp_valid, 1'b1);
        chk("rd0_data", m_resp.resp_data, 32'h0000_1234);
        chk("rd0_sresprdy", s_resp_ready, 4'b0001);
        cyc();
        chk("rd0_done_vld", m_resp_valid, 1'b0);
        chk("rd0_done_rdy", m_req_ready, 1'b1);

        // back-to-back writes to slave 1 then slave 2, valid held high
        m_req.req_addr  = 32'h0200_1000;
        m_req.req_write = 1'b1;
        m_req.req_wdata = 32'hA5A5_0001;
        m_req.req_strb  = 4'hF;
        m_req_valid     = 1'b1;
        cyc();
        chk("wr1_sreqvld", s_req_valid, 4'b0010);
        chk("wr1_sreqaddr", s_req.req_addr, 32'h0200_1000);
        chk("wr1_wdata", s_req.req_wdata, 32'hA5A5_0001);
        m_req.req_addr  = 32'h0200_2000;
        m_req.req_wdata = 32'hA5A5_0002;
        cyc();
        chk("wr1_resp", m_resp_valid, 1'b1);
        chk("wr1_data", m_resp.resp_data, 32'h1111_0001);
        chk("wr1_busy", m_req_ready, 1'b0);
        chk("wr1_hold_sreq", s_req.req_addr, 32'h0200_1000);
        cyc();
        chk("wr2_accept_at3", m_req_ready, 1'b1);
        cyc();
        m_req_valid = 1'b0;
        chk("wr2_sreqvld", s_req_valid, 4'b0100);
        chk("wr2_sreqaddr", s_req.req_addr, 32'h0200_2000);
        chk("wr2_write", s_req.req_write, 1'b1);
        cyc();
        chk("wr2_resp", m_resp_valid, 1'b1);
        chk("wr2_data", m_resp.resp_data, 32'h2222_0002);
        cyc();
        chk("wr2_idle", m_req_ready, 1'b1);

        // unmapped: wrong base, then select beyond SLV_NUM
        m_resp_ready = 1'b0;
        send(32'h0300_0000, 1'b0, 32'h0);
        chk("err1_vld", m_resp_valid, 1'b1);
        chk("err1_data", m_resp.resp_data, 32'h0);
        chk("err1_last", m_resp.resp_last, 1'b1);
        chk("err1_pulse", decode_err, 1'b1);
        chk("err1_addr", err_addr, 32'h0300_0000);
        chk("err1_nosreq", s_req_valid, 4'b0000);
        cyc();
        chk("err1_pulse_end", decode_err, 1'b0);
        chk("err1_vld_hold", m_resp_valid, 1'b1);
        m_resp_ready = 1'b1;
        cyc();
        chk("err1_done", m_resp_valid, 1'b0);
        chk("err1_idle", m_req_ready, 1'b1);
        send(32'h0200_5000, 1'b0, 32'h0);
        chk("err2_pulse", decode_err, 1'b1);
        chk("err2_addr", err_addr, 32'h0200_5000);
        chk("err2_data", m_resp.resp_data, 32'h0);
        chk("err2_nosreq", s_req_valid, 4'b0000);
        cyc();
        chk("err2_done", m_resp_valid, 1'b0);
        chk("err2_addr_keep", err_addr, 32'h0200_5000);

        // response backpressure on slave 0
        slv_data[0]  = 32'h0000_CAFE;
        m_resp_ready = 1'b0;
        send(32'h0200_0008, 1'b0, 32'h0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", m_resp_valid, 1'b1);
            chk("bp_data", m_resp.resp_data, 32'h0000_CAFE);
            chk("bp_sresprdy", s_resp_ready, 4'b0000);
            cyc();
        end
        m_resp_ready = 1'b1;
        #1;
        chk("bp_release", s_resp_ready, 4'b0001);
        cyc();
        chk("bp_done", m_resp_valid, 1'b0);

`ifdef PERI_DEMUX_TIMEOUT_EN
        begin
            int tout_seen;
            int tout_pulses;
            tout_seen   = 0;
            tout_pulses = 0;
            mute[1]     = 1'b1;
            send(32'h0200_1000, 1'b0, 32'h0);
            for (int k = 0; k < 30 && tout_seen == 0; k++) begin
                if (tout_err) begin
                    tout_seen = 1;
                    tout_pulses++;
                    chk("to_vld", m_resp_valid, 1'b1);
                    chk("to_data", m_resp.resp_data, 32'h0);
                    chk("to_err_addr", err_addr, 32'h0200_1000);
                end else begin
                    cyc();
                end
            end
            chk("to_fired", tout_seen, 1);
            for (int k = 0; k < 4; k++) begin
                cyc();
                if (tout_err) tout_pulses++;
            end
            chk("to_once", tout_pulses, 1);
            chk("to_drain_rdy", s_resp_ready, 4'b0010);
            mute[1]     = 1'b0;
            slv_data[1] = 32'h0000_BEEF;
            send(32'h0200_1004, 1'b0, 32'h0);
            for (int k = 0; k < 3; k++) begin
                chk("to_wait_sreq", s_req_valid, 4'b0000);
                cyc();
            end
            late[1] = 1'b1;
            #1;
            chk("to_late_swallow", m_resp_valid, 1'b0);
            cyc();
            late[1] = 1'b0;
            chk("to_resume_sreq", s_req_valid, 4'b0010);
            cyc();
            chk("to_resume_vld", m_resp_valid, 1'b1);
            chk("to_resume_data", m_resp.resp_data, 32'h0000_BEEF);
            cyc();
        end
`endif

        // reset while in RESP, then a normal transaction
        m_resp_ready = 1'b0;
        send(32'h0200_0004, 1'b0, 32'h0);
        cyc();
        chk("rr_in_resp", m_resp_valid, 1'b1);
        rstn = 1'b0;
        cyc();
        chk_reset_outputs("rr");
        rstn         = 1'b1;
        m_resp_ready = 1'b1;
        cyc();
        slv_data[3] = 32'h0000_0055;
        send(32'h0200_3010, 1'b0, 32'h0);
        chk("rr_sreqvld", s_req_valid, 4'b1000);
        cyc();
        chk("rr_vld", m_resp_valid, 1'b1);
        chk("rr_data", m_resp.resp_data, 32'h0000_0055);
        cyc();
        chk("rr_idle", m_req_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
